// File: rtl/piso_tx_32.sv
// piso_tx_32: parallel-in, serial-out transmitter for WIDTH-bit words.
// A word is taken over a valid/ready handshake and shifted out one bit per
// bit_en tick, with ser_valid framing the word and tx_last marking its
// final bit. All state changes on the falling edge of clk.
// Optional feature macro: PISO_TX_BACKTOBACK_EN. When it is defined, a new
// word may be accepted on the edge that consumes the last bit, so words
// stream out with no idle gap. Without it, at least one IDLE cycle
// separates consecutive words.
module piso_tx_32 #(
    parameter int WIDTH     = 32,
    parameter bit MSB_FIRST = 1'b1
) (
    input  logic             clk,
    input  logic             n_reset,
    input  logic [WIDTH-1:0] Datain,
    input  logic             load_valid,
    output logic             load_ready,
    input  logic             bit_en,
    output logic             ser_out,
    output logic             ser_valid,
    output logic             tx_last,
    output logic [15:0]      word_cnt
);

    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0] CNT_FIRST = CW'(WIDTH - 1);

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] shift_q, shift_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [15:0]      word_cnt_q, word_cnt_d;

    logic             in_shift;
    logic             at_last;
    logic             head_bit;

    assign in_shift = (state_q == SHIFT);
    assign at_last  = (cnt_q == '0);
    // The bit on the line is always the one at the head end of the register.
    assign head_bit = MSB_FIRST ? shift_q[WIDTH-1] : shift_q[0];

    // Next-state logic: load in IDLE, shift on bit_en ticks in SHIFT.
    always_comb begin
        state_d    = state_q;
        shift_d    = shift_q;
        cnt_d      = cnt_q;
        word_cnt_d = word_cnt_q;
        case (state_q)
            IDLE: begin
                // bit_en is deliberately ignored here.
                if (load_valid) begin
                    shift_d = Datain;
                    cnt_d   = CNT_FIRST;
                    state_d = SHIFT;
                end
            end
            SHIFT: begin
                if (bit_en) begin
                    if (!at_last) begin
                        // Move the next bit into the head position.
                        if (MSB_FIRST) begin
                            shift_d = {shift_q[WIDTH-2:0], 1'b0};
                        end else begin
                            shift_d = {1'b0, shift_q[WIDTH-1:1]};
                        end
                        cnt_d = cnt_q - 1'b1;
                    end else begin
                        // Last bit consumed: the word counts as sent.
                        word_cnt_d = word_cnt_q + 16'd1;
`ifdef PISO_TX_BACKTOBACK_EN
                        if (load_valid) begin
                            // Chain the next word straight onto this one.
                            shift_d = Datain;
                            cnt_d   = CNT_FIRST;
                            state_d = SHIFT;
                        end else begin
                            state_d = IDLE;
                        end
`else
                        state_d = IDLE;
`endif
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State registers, falling-edge, with synchronous active-low reset.
    always_ff @(negedge clk) begin
        if (!n_reset) begin
            state_q    <= IDLE;
            shift_q    <= '0;
            cnt_q      <= '0;
            word_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            shift_q    <= shift_d;
            cnt_q      <= cnt_d;
            word_cnt_q <= word_cnt_d;
        end
    end

    // Output decode: registered state gated by n_reset so all outputs are
    // quiet while reset is asserted.
    always_comb begin
        ser_valid = n_reset & in_shift;
        ser_out   = n_reset & in_shift & head_bit;
        tx_last   = n_reset & in_shift & at_last;
        word_cnt  = n_reset ? word_cnt_q : 16'd0;
`ifdef PISO_TX_BACKTOBACK_EN
        load_ready = n_reset & (~in_shift | (at_last & bit_en));
`else
        load_ready = n_reset & ~in_shift;
`endif
    end

endmodule

// File: tb/tb_piso_tx_32.sv
// Testbench for piso_tx_32. Two instances share clock, reset, data and
// bit_en: dut_m sends MSB first, dut_l LSB first; each has its own
// load_valid. Stimulus pushes per-cycle expected bits into a queue per
// instance; a monitor per instance pops and compares whenever ser_valid=1.
module tb_piso_tx_32;

    logic        clk = 1'b0;
    logic        n_reset;
    logic        bit_en;
    logic [31:0] datain;
    logic        lv_m, lv_l;
    logic        lr_m, lr_l;
    logic        so_m, so_l;
    logic        sv_m, sv_l;
    logic        tl_m, tl_l;
    logic [15:0] wc_m, wc_l;

    typedef struct packed {
        logic b;
        logic last;
    } exp_t;

    exp_t q_m[$];
    exp_t q_l[$];
    exp_t e_m, e_l;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    piso_tx_32 #(.WIDTH(32), .MSB_FIRST(1'b1)) dut_m (
        .clk(clk), .n_reset(n_reset), .Datain(datain),
        .load_valid(lv_m), .load_ready(lr_m), .bit_en(bit_en),
        .ser_out(so_m), .ser_valid(sv_m), .tx_last(tl_m), .word_cnt(wc_m)
    );

    piso_tx_32 #(.WIDTH(32), .MSB_FIRST(1'b0)) dut_l (
        .clk(clk), .n_reset(n_reset), .Datain(datain),
        .load_valid(lv_l), .load_ready(lr_l), .bit_en(bit_en),
        .ser_out(so_l), .ser_valid(sv_l), .tx_last(tl_l), .word_cnt(wc_l)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic rdy(input bit lsb);
        return lsb ? lr_l : lr_m;
    endfunction

    function automatic logic sv(input bit lsb);
        return lsb ? sv_l : sv_m;
    endfunction

    // Monitor for the MSB-first instance.
    always @(posedge clk) begin
        if (sv_m === 1'b1) begin
            if (q_m.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL msb_unexpected_valid: got ser_valid=1 expected 0 at %0t", $time);
            end else begin
                e_m = q_m.pop_front();
                chk("msb_ser_out", {31'd0, so_m}, {31'd0, e_m.b});
                chk("msb_tx_last", {31'd0, tl_m}, {31'd0, e_m.last});
            end
        end
    end

    // Monitor for the LSB-first instance.
    always @(posedge clk) begin
        if (sv_l === 1'b1) begin
            if (q_l.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL lsb_unexpected_valid: got ser_valid=1 expected 0 at %0t", $time);
            end else begin
                e_l = q_l.pop_front();
                chk("lsb_ser_out", {31'd0, so_l}, {31'd0, e_l.b});
                chk("lsb_tx_last", {31'd0, tl_l}, {31'd0, e_l.last});
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Expected per-cycle line values when each bit is held for 'hold' cycles.
    task automatic push_word(input bit lsb, input logic [31:0] data, input int hold);
        for (int k = 0; k < 32 * hold; k++) begin
            int idx;
            exp_t e;
            idx    = k / hold;
            e.b    = lsb ? data[idx] : data[31 - idx];
            e.last = (idx == 31);
            if (lsb) q_l.push_back(e);
            else     q_m.push_back(e);
        end
        $display("word %08h queued on %s, hold %0d", data, lsb ? "lsb" : "msb", hold);
    endtask

    // Present a word and wait (bounded) for the handshake edge.
    task automatic start_word(input bit lsb, input logic [31:0] data, input int hold);
        bit got;
        got    = 1'b0;
        datain = data;
        if (lsb) lv_l = 1'b1;
        else     lv_m = 1'b1;
        for (int t = 0; t < 100 && !got; t++) begin
            #1;
            if (rdy(lsb) === 1'b1) got = 1'b1;
            else step();
        end
        chk("handshake", {31'd0, got}, 32'd1);
        if (got) push_word(lsb, data, hold);
        step();
        lv_l = 1'b0;
        lv_m = 1'b0;
    endtask

    // Drive bit_en for one full word from SHIFT cycle 0 onwards.
    task automatic shift_bits(input bit lsb, input int hold, input bit scramble);
        for (int k = 0; k < 32 * hold; k++) begin
            logic exp_rdy;
            bit_en = ((k % hold) == hold - 1);
            if (scramble) datain = 32'hDEAD_BEEF ^ k;
`ifdef PISO_TX_BACKTOBACK_EN
            exp_rdy = (k == 32 * hold - 1);
`else
            exp_rdy = 1'b0;
`endif
            #1;
            chk("ser_valid_in_word", {31'd0, sv(lsb)}, 32'd1);
            chk("load_ready_in_word", {31'd0, rdy(lsb)}, {31'd0, exp_rdy});
            step();
        end
        bit_en = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        n_reset = 1'b0;
        lv_m    = 1'b1;
        lv_l    = 1'b0;
        datain  = 32'hFFFF_FFFF;
        bit_en  = 1'b0;

        // Reset held for two edges with a word on offer.
        for (int i = 0; i < 2; i++) begin
            step();
            #1;
            chk("rst_load_ready", {31'd0, lr_m}, 32'd0);
            chk("rst_ser_out", {31'd0, so_m}, 32'd0);
            chk("rst_ser_valid", {31'd0, sv_m}, 32'd0);
            chk("rst_word_cnt", {16'd0, wc_m}, 32'd0);
        end
        step();
        n_reset = 1'b1;
        lv_m    = 1'b0;
        #1;
        chk("rel_load_ready", {31'd0, lr_m}, 32'd1);
        chk("rel_ser_valid", {31'd0, sv_m}, 32'd0);
        step();
        #1;
        chk("rel_no_transfer", {31'd0, sv_m}, 32'd0);
        chk("rel_word_cnt", {16'd0, wc_m}, 32'd0);

        // Single word, MSB first: 1,0,1,0,0,1,0,1, 23 zeros, then 1.
        start_word(1'b0, 32'hA500_0001, 1);
        shift_bits(1'b0, 1, 1'b1);
        #1;
        chk("single_end_valid", {31'd0, sv_m}, 32'd0);
        chk("single_queue_empty", q_m.size(), 32'd0);
        chk("single_word_cnt", {16'd0, wc_m}, 32'd1);

        // Throttled, LSB first: each bit held 4 cycles, Datain scrambled.
        start_word(1'b1, 32'h0000_0003, 4);
        shift_bits(1'b1, 4, 1'b1);
        #1;
        chk("throttle_end_valid", {31'd0, sv_l}, 32'd0);
        chk("throttle_queue_empty", q_l.size(), 32'd0);
        chk("throttle_word_cnt", {16'd0, wc_l}, 32'd1);

`ifdef PISO_TX_BACKTOBACK_EN
        // Back-to-back: 64 consecutive bits with no gap.
        start_word(1'b0, 32'h8000_0000, 1);
        lv_m   = 1'b1;
        datain = 32'h0000_0001;
        for (int k = 0; k < 32; k++) begin
            bit_en = 1'b1;
            #1;
            chk("b2b_ser_valid", {31'd0, sv_m}, 32'd1);
            chk("b2b_load_ready", {31'd0, lr_m}, {31'd0, (k == 31)});
            if (k == 31) push_word(1'b0, 32'h0000_0001, 1);
            step();
        end
        lv_m = 1'b0;
        shift_bits(1'b0, 1, 1'b0);
        #1;
        chk("b2b_end_valid", {31'd0, sv_m}, 32'd0);
        chk("b2b_queue_empty", q_m.size(), 32'd0);
        chk("b2b_word_cnt", {16'd0, wc_m}, 32'd3);
`else
        // Handshake stall: next word offered during SHIFT waits for IDLE.
        start_word(1'b0, 32'hC3C3_0F0F, 1);
        lv_m   = 1'b1;
        datain = 32'h5A5A_A5A5;
        shift_bits(1'b0, 1, 1'b0);
        #1;
        chk("stall_gap_valid", {31'd0, sv_m}, 32'd0);
        chk("stall_first_cnt", {16'd0, wc_m}, 32'd2);
        start_word(1'b0, 32'h5A5A_A5A5, 1);
        shift_bits(1'b0, 1, 1'b0);
        #1;
        chk("stall_end_valid", {31'd0, sv_m}, 32'd0);
        chk("stall_queue_empty", q_m.size(), 32'd0);
        chk("stall_word_cnt", {16'd0, wc_m}, 32'd3);
`endif

        // Reset after 10 bits: word is abandoned, reset clears word_cnt.
        start_word(1'b0, 32'hF0F0_1234, 1);
        for (int k = 0; k < 10; k++) begin
            bit_en = 1'b1;
            step();
        end
        n_reset = 1'b0;
        #1;
        chk("midrst_ser_valid", {31'd0, sv_m}, 32'd0);
        chk("midrst_ser_out", {31'd0, so_m}, 32'd0);
        step();
        n_reset = 1'b1;
        bit_en  = 1'b0;
        q_m.delete();
        #1;
        chk("postrst_ser_valid", {31'd0, sv_m}, 32'd0);
        chk("postrst_load_ready", {31'd0, lr_m}, 32'd1);
        chk("postrst_word_cnt", {16'd0, wc_m}, 32'd0);
        chk("postrst_lsb_word_cnt", {16'd0, wc_l}, 32'd0);

        // word_cnt wrap: preload 0xFFFF, send one word.
        force dut_m.word_cnt_q = 16'hFFFF;
        step();
        release dut_m.word_cnt_q;
        #1;
        chk("wrap_preload", {16'd0, wc_m}, 32'h0000_FFFF);
        start_word(1'b0, 32'h0000_0001, 1);
        shift_bits(1'b0, 1, 1'b0);
        #1;
        chk("wrap_word_cnt", {16'd0, wc_m}, 32'd0);
        chk("wrap_queue_empty", q_m.size(), 32'd0);

        step();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
